mdu_hilo: RTL

//  Iterative multi-cycle multiply/divide unit with architectural HI/LO registers.

---
 rtl/mdu_hilo_if.sv | 28 ++
 rtl/mdu_hilo.sv | 127 ++++++++++++
 2 files changed

// File: rtl/mdu_hilo_if.sv
// Handshake and result bundle between the EXE stage and the multiply/divide unit.
// The master drives requests and HI/LO moves; the slave returns status and HI/LO.
interface mdu_hilo_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] Op1;
  logic [WIDTH-1:0] Op2;
  logic             flush;
  logic             mthi;
  logic             mtlo;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, Op1, Op2, flush, mthi, mtlo,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, Op1, Op2, flush, mthi, mtlo,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mdu_hilo.sv
// Iterative radix-2 multiply/divide unit owning the architectural HI/LO registers.
// Products land as {hi, lo}; quotients in lo and remainders in hi after WIDTH CALC cycles.
module mdu_hilo #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input logic        clk,
  input logic        rst,
  mdu_hilo_if.slave  bus
);

  typedef enum logic {IDLE, CALC} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               dz_r;
  logic               done_r;
  logic               dz_out;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic               is_signed;
  logic               accept;
  logic               last_step;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;

  assign is_signed = ~bus.op[0];
  assign accept    = (state == IDLE) && bus.start && !bus.flush;
  assign last_step = (cnt == CNT_W'(WIDTH - 1));
  assign a_mag     = (is_signed && bus.Op1[WIDTH-1]) ? -bus.Op1 : bus.Op1;
  assign b_mag     = (is_signed && bus.Op2[WIDTH-1]) ? -bus.Op2 : bus.Op2;

  // One iteration: multiply adds into the upper half then shifts right; divide shifts
  // the remainder left and keeps the trial subtraction only when it does not borrow.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opb};
    acc_step  = {mul_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (div_trial[WIDTH])
        acc_step = {acc[2*WIDTH-2:0], 1'b0};
      else
        acc_step = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
    prod_fix = neg_q ? -acc_step : acc_step;
    q_fix    = dz_r ? '1 : (neg_q ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0]);
    r_fix    = neg_r ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CALC;
      CALC:    if (bus.flush || last_step) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opb    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz_r   <= 1'b0;
      done_r <= 1'b0;
      dz_out <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      state  <= state_next;
      done_r <= 1'b0;
      dz_out <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          cnt    <= '0;
          acc    <= {{WIDTH{1'b0}}, a_mag};
          opb    <= b_mag;
          is_div <= bus.op[1];
          neg_q  <= is_signed && (bus.Op1[WIDTH-1] ^ bus.Op2[WIDTH-1]);
          neg_r  <= is_signed && bus.op[1] && bus.Op1[WIDTH-1];
          dz_r   <= bus.op[1] && (bus.Op2 == '0);
        end else if (!bus.start) begin
          // A start in the same cycle, even a flushed one, suppresses the move.
          if (bus.mthi) hi_r <= bus.Op1;
          if (bus.mtlo) lo_r <= bus.Op1;
        end
      end else if (!bus.flush) begin
        acc <= acc_step;
        cnt <= cnt + 1'b1;
        if (last_step) begin
          if (is_div) begin
            hi_r <= r_fix;
            lo_r <= q_fix;
          end else begin
            hi_r <= prod_fix[2*WIDTH-1:WIDTH];
            lo_r <= prod_fix[WIDTH-1:0];
          end
          done_r <= 1'b1;
          dz_out <= dz_r;
        end
      end
    end
  end

  assign bus.busy        = (state == CALC);
  assign bus.done        = done_r;
  assign bus.div_by_zero = dz_out;
  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;

endmodule
